// File: rtl/threshold_binarizer_mc.sv
// Multi-channel threshold binarizer: 2*x - offset compared against a shared signed threshold.
// Optional hysteresis per channel is enabled by defining THRESHOLD_BINARIZER_HYSTERESIS_EN.
module threshold_binarizer_mc #(
  parameter int IL   = 10,
  parameter int NCH  = 4,
  parameter int OL   = 11,
  parameter int NSEL = 16,
  parameter int CW   = 16,
  parameter int HYS  = 4,
  localparam int SW  = (NSEL > 1) ? $clog2(NSEL) : 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iEN,
  input  logic [NCH*IL-1:0] iDATA,
  input  logic [IL-1:0]     iTH,
  input  logic [SW-1:0]     iSEL,
  input  logic              iCFG_WE,
  input  logic [SW-1:0]     iCFG_ADDR,
  input  logic [OL-1:0]     iCFG_OFS,
  input  logic              iCFG_STRICT,
  input  logic              iCLR,
  output logic [NCH-1:0]    oDATA,
  output logic              oEN,
  output logic [CW-1:0]     oCNT
);

  localparam int W = IL + 3;

  logic [OL-1:0]     tbl_ofs    [NSEL];
  logic              tbl_strict [NSEL];
  logic              wr_ok;
  logic              rd_ok;
  logic [OL-1:0]     sel_ofs;
  logic              sel_strict;

  logic              v1;
  logic [NCH*IL-1:0] data1;
  logic [IL-1:0]     th1;
  logic [OL-1:0]     ofs1;
  logic              strict1;

  logic signed [W-1:0] th_ext;
  logic signed [W-1:0] val;
  logic signed [W-1:0] thr;
  logic [NCH-1:0]      new_bits;
  logic [CW:0]         pop;
  logic [CW:0]         sum;

  // Indices past NSEL read as a zero entry and are never written.
  assign wr_ok      = 32'(iCFG_ADDR) < NSEL;
  assign rd_ok      = 32'(iSEL) < NSEL;
  assign sel_ofs    = rd_ok ? tbl_ofs[iSEL] : '0;
  assign sel_strict = rd_ok ? tbl_strict[iSEL] : 1'b0;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < NSEL; i++) begin
        tbl_ofs[i]    <= '0;
        tbl_strict[i] <= 1'b0;
      end
    end else if (iCFG_WE && wr_ok) begin
      tbl_ofs[iCFG_ADDR]    <= iCFG_OFS;
      tbl_strict[iCFG_ADDR] <= iCFG_STRICT;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v1      <= 1'b0;
      data1   <= '0;
      th1     <= '0;
      ofs1    <= '0;
      strict1 <= 1'b0;
    end else begin
      v1 <= iEN;
      if (iEN) begin
        data1   <= iDATA;
        th1     <= iTH;
        ofs1    <= sel_ofs;
        strict1 <= sel_strict;
      end
    end
  end

  assign th_ext = {{(W-IL){th1[IL-1]}}, th1};

`ifdef THRESHOLD_BINARIZER_HYSTERESIS_EN
  localparam logic signed [W-1:0] HYS_W = W'(HYS);
  logic [NCH-1:0] hys_state;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)
      hys_state <= '0;
    else if (v1)
      hys_state <= new_bits;
    else if (iCLR)
      hys_state <= '0;
  end
`else
  logic [31:0] unused_hys;
  assign unused_hys = 32'(HYS);
`endif

  // Headroom of two extra bits keeps 2*x - offset from ever wrapping.
  always_comb begin
    new_bits = '0;
    val      = '0;
    thr      = '0;
    for (int k = 0; k < NCH; k++) begin
      val = $signed({{(W-IL-1){1'b0}}, data1[k*IL +: IL], 1'b0})
          - $signed({{(W-OL){1'b0}}, ofs1});
`ifdef THRESHOLD_BINARIZER_HYSTERESIS_EN
      thr = hys_state[k] ? (th_ext - HYS_W) : (th_ext + HYS_W);
`else
      thr = th_ext;
`endif
      new_bits[k] = strict1 ? (val > thr) : (val >= thr);
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oEN   <= 1'b0;
      oDATA <= '0;
    end else begin
      oEN <= v1;
      if (v1)
        oDATA <= new_bits;
    end
  end

  // A clear during an output cycle restarts the count from that output's ones.
  always_comb begin
    pop = '0;
    for (int k = 0; k < NCH; k++)
      pop = pop + {{CW{1'b0}}, oDATA[k]};
    sum = (iCLR ? {(CW+1){1'b0}} : {1'b0, oCNT}) + pop;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)
      oCNT <= '0;
    else if (oEN)
      oCNT <= sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
    else if (iCLR)
      oCNT <= '0;
  end

endmodule

// File: tb/tb_threshold_binarizer_mc.sv
// Directed bench for threshold_binarizer_mc; a second instance with a 4-bit
// counter shares all inputs to exercise counter saturation.
module tb_threshold_binarizer_mc;

  localparam int IL   = 10;
  localparam int NCH  = 4;
  localparam int OL   = 11;
  localparam int NSEL = 16;
  localparam int CW   = 16;
  localparam int HYS  = 4;
  localparam int SW   = 4;

  logic              iCLK = 1'b0;
  logic              iRST;
  logic              iEN;
  logic [NCH*IL-1:0] iDATA;
  logic [IL-1:0]     iTH;
  logic [SW-1:0]     iSEL;
  logic              iCFG_WE;
  logic [SW-1:0]     iCFG_ADDR;
  logic [OL-1:0]     iCFG_OFS;
  logic              iCFG_STRICT;
  logic              iCLR;
  logic [NCH-1:0]    oDATA;
  logic              oEN;
  logic [CW-1:0]     oCNT;
  logic [NCH-1:0]    oDATA_s;
  logic              oEN_s;
  logic [3:0]        oCNT_s;

  int errors = 0;
  int checks = 0;

  always #5 iCLK = ~iCLK;

  threshold_binarizer_mc #(.IL(IL), .NCH(NCH), .OL(OL), .NSEL(NSEL), .CW(CW), .HYS(HYS)) dut (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iDATA(iDATA), .iTH(iTH), .iSEL(iSEL),
    .iCFG_WE(iCFG_WE), .iCFG_ADDR(iCFG_ADDR), .iCFG_OFS(iCFG_OFS), .iCFG_STRICT(iCFG_STRICT),
    .iCLR(iCLR), .oDATA(oDATA), .oEN(oEN), .oCNT(oCNT)
  );

  threshold_binarizer_mc #(.IL(IL), .NCH(NCH), .OL(OL), .NSEL(NSEL), .CW(4), .HYS(HYS)) dut_small (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iDATA(iDATA), .iTH(iTH), .iSEL(iSEL),
    .iCFG_WE(iCFG_WE), .iCFG_ADDR(iCFG_ADDR), .iCFG_OFS(iCFG_OFS), .iCFG_STRICT(iCFG_STRICT),
    .iCLR(iCLR), .oDATA(oDATA_s), .oEN(oEN_s), .oCNT(oCNT_s)
  );

  // All tasks start and end just after a falling edge.
  task automatic step();
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic write_entry(input logic [SW-1:0] a, input logic [OL-1:0] o, input logic s);
    iCFG_WE = 1'b1; iCFG_ADDR = a; iCFG_OFS = o; iCFG_STRICT = s;
    step();
    iCFG_WE = 1'b0;
  endtask

  task automatic send(input logic [IL-1:0] x, input logic [IL-1:0] th, input logic [SW-1:0] sel);
    iEN = 1'b1; iDATA = {NCH{x}}; iTH = th; iSEL = sel;
    step();
    iEN = 1'b0;
  endtask

  task automatic pulse_clear();
    iCLR = 1'b1;
    step();
    iCLR = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    #1;
    checks++; if (oDATA !== 4'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", oDATA); end
    checks++; if (oEN !== 1'b0) begin errors++; $display("[TB] FAIL reset_en: got %b expected 0", oEN); end
    @(negedge iCLK);
    iRST = 1'b0;
    step();
    send(10'd5, 10'd10, 4'd2);
    step();
    checks++; if (oDATA !== 4'hF) begin errors++; $display("[TB] FAIL first_sample: got %h expected f", oDATA); end
    step();
    checks++; if (oCNT !== 16'd4) begin errors++; $display("[TB] FAIL first_count: got %0d expected 4", oCNT); end
    write_entry(4'd7, 11'd100, 1'b0);
    send(10'd5, 10'd10, 4'd2);
    #2 iRST = 1'b1;
    #1;
    checks++; if (oDATA !== 4'h0) begin errors++; $display("[TB] FAIL midreset_data: got %h expected 0", oDATA); end
    checks++; if (oEN !== 1'b0) begin errors++; $display("[TB] FAIL midreset_en: got %b expected 0", oEN); end
    checks++; if (oCNT !== 16'd0) begin errors++; $display("[TB] FAIL midreset_cnt: got %0d expected 0", oCNT); end
    @(negedge iCLK);
    iRST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (oEN !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_en: got %b expected 0", oEN); end
    end
    send(10'd5, 10'd10, 4'd7);
    checks++; if (oEN !== 1'b0) begin errors++; $display("[TB] FAIL table_reset_lat: got %b expected 0", oEN); end
    step();
    checks++; if (oEN !== 1'b1) begin errors++; $display("[TB] FAIL table_reset_en: got %b expected 1", oEN); end
    checks++; if (oDATA !== 4'hF) begin errors++; $display("[TB] FAIL table_reset_bit: got %h expected f", oDATA); end
  endtask

  task automatic test_offset_strict();
    write_entry(4'd3, 11'd672, 1'b1);
    send(10'd341, 10'd10, 4'd3);
    checks++; if (oEN !== 1'b0) begin errors++; $display("[TB] FAIL strict_latency: got %b expected 0", oEN); end
    step();
    checks++; if (oEN !== 1'b1) begin errors++; $display("[TB] FAIL strict_en: got %b expected 1", oEN); end
    checks++; if (oDATA !== 4'h0) begin errors++; $display("[TB] FAIL strict_gt: got %h expected 0", oDATA); end
    write_entry(4'd3, 11'd672, 1'b0);
    send(10'd341, 10'd10, 4'd3);
    step();
    checks++; if (oDATA !== 4'hF) begin errors++; $display("[TB] FAIL nonstrict_ge: got %h expected f", oDATA); end
  endtask

  task automatic test_negative();
    write_entry(4'd0, 11'd1008, 1'b0);
    send(10'd0, 10'h200, 4'd0);
    step();
    checks++; if (oDATA !== 4'h0) begin errors++; $display("[TB] FAIL negative_value: got %h expected 0", oDATA); end
    send(10'd1023, 10'd500, 4'd0);
    step();
    checks++; if (oDATA !== 4'hF) begin errors++; $display("[TB] FAIL no_wrap: got %h expected f", oDATA); end
  endtask

  task automatic test_collision();
    write_entry(4'd1, 11'd4, 1'b0);
    iCFG_WE = 1'b1; iCFG_ADDR = 4'd1; iCFG_OFS = 11'd9; iCFG_STRICT = 1'b0;
    iEN = 1'b1; iDATA = {NCH{10'd7}}; iTH = 10'd10; iSEL = 4'd1;
    step();
    iCFG_WE = 1'b0; iEN = 1'b0;
    step();
    checks++; if (oDATA !== 4'hF) begin errors++; $display("[TB] FAIL collision_old: got %h expected f", oDATA); end
    send(10'd7, 10'd10, 4'd1);
    step();
    checks++; if (oDATA !== 4'h0) begin errors++; $display("[TB] FAIL collision_new: got %h expected 0", oDATA); end
  endtask

  task automatic test_counter();
    pulse_clear();
    checks++; if (oCNT !== 16'd0) begin errors++; $display("[TB] FAIL clear_idle: got %0d expected 0", oCNT); end
    checks++; if (oCNT_s !== 4'd0) begin errors++; $display("[TB] FAIL clear_idle_small: got %0d expected 0", oCNT_s); end
    step();
    checks++; if (oDATA !== 4'h0) begin errors++; $display("[TB] FAIL hold_data: got %h expected 0", oDATA); end
    iEN = 1'b1; iDATA = {NCH{10'd5}}; iTH = 10'd10; iSEL = 4'd2;
    for (int i = 0; i < 5; i++) step();
    iEN = 1'b0;
    step();
    step();
    checks++; if (oCNT !== 16'd20) begin errors++; $display("[TB] FAIL count_20: got %0d expected 20", oCNT); end
    checks++; if (oCNT_s !== 4'd15) begin errors++; $display("[TB] FAIL count_saturate: got %0d expected 15", oCNT_s); end
    send(10'd5, 10'd10, 4'd2);
    step();
    checks++; if (oEN !== 1'b1) begin errors++; $display("[TB] FAIL sixth_en: got %b expected 1", oEN); end
    pulse_clear();
    checks++; if (oCNT !== 16'd4) begin errors++; $display("[TB] FAIL clear_with_add: got %0d expected 4", oCNT); end
    checks++; if (oCNT_s !== 4'd4) begin errors++; $display("[TB] FAIL clear_with_add_small: got %0d expected 4", oCNT_s); end
  endtask

  task automatic test_hysteresis();
    logic [IL-1:0] xs [4];
    logic [SW-1:0] sels [4];
    logic          expb [4];
    xs   = '{10'd6, 10'd8, 10'd4, 10'd3};
    sels = '{4'd4, 4'd5, 4'd4, 4'd5};
`ifdef THRESHOLD_BINARIZER_HYSTERESIS_EN
    expb = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
    expb = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
    write_entry(4'd4, 11'd0, 1'b0);
    write_entry(4'd5, 11'd1, 1'b0);
    pulse_clear();
    for (int i = 0; i < 4; i++) begin
      send(xs[i], 10'd10, sels[i]);
      step();
      checks++;
      if (oDATA !== {NCH{expb[i]}}) begin
        errors++;
        $display("[TB] FAIL hysteresis_%0d: got %h expected %h", i, oDATA, {NCH{expb[i]}});
      end
    end
  endtask

  initial begin
    iRST = 1'b1; iEN = 1'b0; iDATA = '0; iTH = '0; iSEL = '0;
    iCFG_WE = 1'b0; iCFG_ADDR = '0; iCFG_OFS = '0; iCFG_STRICT = 1'b0; iCLR = 1'b0;
    @(negedge iCLK);
    test_reset();
    test_offset_strict();
    test_negative();
    test_collision();
    test_counter();
    test_hysteresis();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
